// File: rtl/pe_pkg.sv
// Shared definitions for the single-PE dot-product engine: FSM encoding,
// BRAM timing constants and an address helper.
package pe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    WRITE,
    DONE
  } state_t;

  localparam int         BRAM_RD_LATENCY = 2;
  localparam int         DONE_HOLD       = 5;
  localparam logic [3:0] WE_ALL          = 4'hF;

  // BRAM_ADDR is a byte address; the BRAM is organised in 32-bit words.
  function automatic logic [31:0] word_addr(input int unsigned word);
    return word << 2;
  endfunction

endpackage

// File: rtl/pe_mac.sv
// Local copy of vector A plus the 32-bit multiply-accumulator that consumes it.
// The RAM read is combinational so the operand is ready in the cycle it is used.
module pe_mac #(
  parameter int L_RAM_SIZE = 6
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  wr_en,
  input  logic [L_RAM_SIZE-1:0] wr_addr,
  input  logic [31:0]           wr_data,
  input  logic [L_RAM_SIZE-1:0] rd_addr,
  input  logic                  acc_clr,
  input  logic                  acc_en,
  input  logic [31:0]           operand,
  output logic [31:0]           sum
);

  logic [31:0] ram [2**L_RAM_SIZE];
  logic [31:0] acc;
  logic [31:0] product;

  // NOTE: the RAM has no reset; its contents are always rewritten by LOAD
  // before CALC reads them, and leaving it unreset lets it map onto block RAM.
  always_ff @(posedge aclk) begin
    if (wr_en) ram[wr_addr] <= wr_data;
  end

  // Both the product and the running sum keep only the low 32 bits.
  assign product = operand * ram[rd_addr];
  assign sum     = acc + product;

  // NOTE: state registers use non-blocking assignments only, so every
  // always_ff sees the values from before the clock edge.
  always_ff @(posedge aclk) begin
    if (aresetn)      acc <= '0;
    else if (acc_clr) acc <= '0;
    else if (acc_en)  acc <= sum;
  end

endmodule

// File: rtl/pe_controller.sv
// Dot-product controller: copies A into the local RAM, streams B through the
// MAC, writes the 32-bit result to BRAM word 0 and holds done for DONE_HOLD cycles.
module pe_controller
  import pe_pkg::*;
#(
  parameter int VECTOR_SIZE = 64,
  parameter int L_RAM_SIZE  = 6
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  output logic        done,
  output logic [31:0] BRAM_ADDR,
  output logic [31:0] BRAM_WRDATA,
  output logic [3:0]  BRAM_WE,
  output logic        BRAM_CLK,
  input  logic [31:0] BRAM_RDDATA
);

  // Wide enough for VECTOR_SIZE + BRAM_RD_LATENCY since VECTOR_SIZE <= 2^L_RAM_SIZE.
  localparam int CNT_W = L_RAM_SIZE + 2;
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(VECTOR_SIZE + BRAM_RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(DONE_HOLD - 1);
  localparam logic [CNT_W-1:0] LAT       = CNT_W'(BRAM_RD_LATENCY);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_next;
  logic                    start_seen;
  logic                    ram_wr_en;
  logic                    acc_clr;
  logic                    acc_en;
  logic [L_RAM_SIZE-1:0]   ram_addr;
  logic [31:0]             mac_sum;

  assign BRAM_CLK = aclk;
  assign cnt_next = cnt + CNT_W'(1);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ram_wr_en = 1'b0;
    acc_en    = 1'b0;
    acc_clr   = 1'b0;
    ram_addr  = L_RAM_SIZE'(cnt - LAT);
    case (state)
      IDLE:    acc_clr   = start_seen;
      LOAD:    ram_wr_en = (cnt >= LAT);
      CALC:    acc_en    = (cnt >= LAT);
      default: ;
    endcase
  end

  pe_mac #(
    .L_RAM_SIZE(L_RAM_SIZE)
  ) u_mac (
    .aclk    (aclk),
    .aresetn (aresetn),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_addr),
    .wr_data (BRAM_RDDATA),
    .rd_addr (ram_addr),
    .acc_clr (acc_clr),
    .acc_en  (acc_en),
    .operand (BRAM_RDDATA),
    .sum     (mac_sum)
  );

  // start is registered once while IDLE; the run launches from that flag.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      state       <= IDLE;
      cnt         <= '0;
      start_seen  <= 1'b0;
      done        <= 1'b0;
      BRAM_ADDR   <= '0;
      BRAM_WRDATA <= '0;
      BRAM_WE     <= '0;
    end else begin
      case (state)
        IDLE: begin
          BRAM_WE <= '0;
          done    <= 1'b0;
          if (start_seen) begin
            start_seen <= 1'b0;
            state      <= LOAD;
            cnt        <= '0;
            BRAM_ADDR  <= word_addr(0);
          end else begin
            start_seen <= start;
          end
        end
        LOAD: begin
          if (cnt == LAST) begin
            state     <= CALC;
            cnt       <= '0;
            BRAM_ADDR <= word_addr(VECTOR_SIZE);
          end else begin
            cnt <= cnt_next;
            if (int'(cnt_next) < VECTOR_SIZE) BRAM_ADDR <= word_addr(int'(cnt_next));
          end
        end
        CALC: begin
          if (cnt == LAST) begin
            // mac_sum already includes the final product being accumulated now.
            state       <= WRITE;
            cnt         <= '0;
            BRAM_ADDR   <= word_addr(0);
            BRAM_WRDATA <= mac_sum;
            BRAM_WE     <= WE_ALL;
          end else begin
            cnt <= cnt_next;
            if (int'(cnt_next) < VECTOR_SIZE)
              BRAM_ADDR <= word_addr(VECTOR_SIZE + int'(cnt_next));
          end
        end
        WRITE: begin
          state   <= DONE;
          BRAM_WE <= '0;
          done    <= 1'b1;
          cnt     <= '0;
        end
        DONE: begin
          if (cnt == HOLD_LAST) begin
            state <= IDLE;
            done  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_controller.sv
// Self-checking bench for pe_controller: a two-cycle-latency BRAM model, a
// plain-arithmetic dot-product reference, and directed plus random runs.
module tb_pe_controller;

  localparam int N = 64;
  localparam int L = 6;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start;
  logic        done;
  logic [31:0] BRAM_ADDR;
  logic [31:0] BRAM_WRDATA;
  logic [3:0]  BRAM_WE;
  logic        BRAM_CLK;
  logic [31:0] BRAM_RDDATA;

  always #5 aclk = ~aclk;

  pe_controller #(
    .VECTOR_SIZE(N),
    .L_RAM_SIZE (L)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .start       (start),
    .done        (done),
    .BRAM_ADDR   (BRAM_ADDR),
    .BRAM_WRDATA (BRAM_WRDATA),
    .BRAM_WE     (BRAM_WE),
    .BRAM_CLK    (BRAM_CLK),
    .BRAM_RDDATA (BRAM_RDDATA)
  );

  // BRAM model: read data appears two cycles after the address; the host
  // port loads words while the engine is idle.
  logic [31:0] mem [256];
  logic [31:0] rd_pipe;
  logic        host_we = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [31:0] host_data = '0;
  int          we_count = 0;
  logic [31:0] last_we_addr = '0;

  always @(posedge aclk) begin
    rd_pipe     <= mem[BRAM_ADDR[9:2]];
    BRAM_RDDATA <= rd_pipe;
    if (host_we) mem[host_addr] <= host_data;
    else
      for (int b = 0; b < 4; b++)
        if (BRAM_WE[b]) mem[BRAM_ADDR[9:2]][8*b +: 8] <= BRAM_WRDATA[8*b +: 8];
    if (BRAM_WE != 4'h0) begin
      we_count     <= we_count + 1;
      last_we_addr <= BRAM_ADDR;
    end
  end

  int checks = 0;
  int passes = 0;
  logic [31:0] va [N];
  logic [31:0] vb [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] dot_model();
    logic [31:0] s = 32'd0;
    for (int i = 0; i < N; i++) s = s + va[i] * vb[i];
    return s;
  endfunction

  task automatic load_vectors();
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge aclk);
      host_we   = 1'b1;
      host_addr = 8'(i);
      host_data = (i < N) ? va[i] : vb[i - N];
    end
    @(negedge aclk);
    host_we = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
    end
  endtask

  // One full computation. hold_start keeps start high until done; poke sends
  // extra start pulses during CALC and DONE that must be ignored.
  task automatic run(input string tag, input bit hold_start, input bit poke);
    logic [31:0] expected;
    int lat;
    int hi;
    int we_before;
    expected = dot_model();
    load_vectors();
    we_before = we_count;
    @(negedge aclk);
    start = 1'b1;
    @(posedge aclk);
    #1;
    if (!hold_start) start = 1'b0;
    lat = 0;
    while (!done && lat < 400) begin
      @(posedge aclk);
      #1;
      lat++;
      if (poke && lat == N + 20) start = 1'b1;
      if (poke && lat == N + 21) start = 1'b0;
    end
    check({tag, "_latency"}, 32'(lat), 32'(2 * N + 6));
    hi = done ? 1 : 0;
    start = 1'b0;
    while (done && hi < 20) begin
      @(posedge aclk);
      #1;
      if (done) hi++;
      if (poke && hi == 2) start = 1'b1;
      if (poke && hi == 3) start = 1'b0;
    end
    start = 1'b0;
    check({tag, "_done_cycles"}, 32'(hi), 32'd5);
    check({tag, "_result"}, mem[0], expected);
    check({tag, "_write_count"}, 32'(we_count - we_before), 32'd1);
    check({tag, "_write_addr"}, last_we_addr, 32'd0);
    if (hold_start || poke) begin
      repeat (2 * N + 20) @(posedge aclk);
      #1;
      check({tag, "_no_rerun"}, 32'(we_count - we_before), 32'd1);
    end
  endtask

  initial begin
    int lat;
    int we_before;
    logic [31:0] word0;

    aresetn = 1'b1;
    start   = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_we", {28'd0, BRAM_WE}, 32'd0);
    check("reset_addr", BRAM_ADDR, 32'd0);
    check("reset_wrdata", BRAM_WRDATA, 32'd0);
    @(negedge aclk);
    aresetn = 1'b0;

    for (int i = 0; i < N; i++) begin va[i] = 32'd1; vb[i] = 32'(i + 1); end
    run("ones_ramp", 1'b0, 1'b0);

    for (int i = 0; i < N; i++) begin va[i] = 32'(i); vb[i] = 32'(i); end
    run("squares", 1'b0, 1'b0);

    for (int i = 0; i < N; i++) begin va[i] = 32'hFFFF_FFFF; vb[i] = 32'd2; end
    run("negative", 1'b0, 1'b0);

    for (int i = 0; i < N; i++) begin va[i] = 32'h0001_0000; vb[i] = 32'h0001_0000; end
    run("wrap", 1'b0, 1'b0);

    fill_random();
    run("held_start", 1'b1, 1'b0);
    run("poked_start", 1'b0, 1'b1);
    run("rerun_same", 1'b0, 1'b0);

    // Abort mid-CALC: nothing may be written and the engine must idle cleanly.
    fill_random();
    load_vectors();
    word0 = va[0];
    we_before = we_count;
    @(negedge aclk);
    start = 1'b1;
    @(posedge aclk);
    #1;
    start = 1'b0;
    lat = 0;
    while (lat < N + 20) begin
      @(posedge aclk);
      #1;
      lat++;
    end
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_we", {28'd0, BRAM_WE}, 32'd0);
    check("abort_addr", BRAM_ADDR, 32'd0);
    aresetn = 1'b0;
    repeat (2 * N + 20) @(posedge aclk);
    #1;
    check("abort_no_write", 32'(we_count - we_before), 32'd0);
    check("abort_word0", mem[0], word0);
    check("abort_idle_done", {31'd0, done}, 32'd0);
    run("after_abort", 1'b0, 1'b0);

    for (int r = 0; r < 2; r++) begin
      fill_random();
      run($sformatf("random%0d", r), 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pe_controller.md
Name: pe_controller

Overview:
- Single-PE dot-product engine with one 32-bit BRAM port.
- On `start` it copies vector A from BRAM into a local RAM, then streams vector B from BRAM and multiply-accumulates against the local copy.
- It writes the 32-bit result back to BRAM and signals `done`.
- It sits between a host-loaded BRAM (modelled by my_bram) and the host.

Parameters:
- VECTOR_SIZE, 64, number of elements per vector; must satisfy VECTOR_SIZE ≤ 2^L_RAM_SIZE.
- L_RAM_SIZE, 6, log2 of local RAM depth.

Ports:
- aclk, input, 1: sole clock for all logic.
- aresetn, input, 1: reset, synchronous and active-high (1 = reset), sampled on the rising edge of aclk.
- start, input, 1: level sampled in IDLE; a one-cycle pulse is sufficient.
- done, output, 1: completion flag.
- BRAM_ADDR, output, 32: byte address; word index = BRAM_ADDR >> 2.
- BRAM_WRDATA, output, 32: write data.
- BRAM_WE, output, 4: byte write enables.
- BRAM_CLK, output, 1: equals aclk, passed through combinationally.
- BRAM_RDDATA, input, 32: read data; valid 2 cycles after the address is presented.

Behaviour:
- Reset (aresetn = 1 at a clock edge) forces:
  - state IDLE;
  - done = 0, BRAM_WE = 0, BRAM_ADDR = 0, BRAM_WRDATA = 0;
  - accumulator = 0 and all counters = 0.
  - Reset mid-operation aborts immediately; no write is performed. Local RAM contents are don't-care.
- BRAM memory map, in words:
  - words 0..N-1 hold vector A;
  - words N..2N-1 hold vector B;
  - the result is written to word 0.
- Data format: 32-bit two's-complement integers. Each product is truncated to 32 bits; the accumulator wraps modulo 2^32.
- IDLE:
  - BRAM_WE = 0.
  - start = 1 → clear the accumulator, go to LOAD.
  - start is ignored in every other state.
- LOAD, N+2 cycles:
  - Cycle i < N: BRAM_ADDR = 4*i.
  - Cycle i ≥ 2: local_ram[i-2] ← BRAM_RDDATA.
  - After the last capture, go to CALC.
- CALC, N+2 cycles:
  - Cycle i < N: BRAM_ADDR = 4*(N+i).
  - Cycle i ≥ 2: acc ← acc + BRAM_RDDATA * local_ram[i-2], registered the same cycle.
  - Then go to WRITE.
- WRITE, 1 cycle: BRAM_ADDR = 0, BRAM_WRDATA = acc, BRAM_WE = 4'hF. Then go to DONE.
- DONE:
  - done = 1 for exactly 5 cycles, BRAM_WE = 0, then return to IDLE.
  - start during DONE is ignored.
- Latency: done first rises 2N+6 rising edges after the edge that samples start (134 for N = 64).
- BRAM_WE is 0 in every state except WRITE; the BRAM is never written during LOAD or CALC.
- Local RAM: depth 2^L_RAM_SIZE, 32-bit wide, synchronous write. The read must be available the cycle it is used, either combinational or prefetched one cycle early.

Decomposition:
- Shared package pe_pkg holds:
  - state encoding: IDLE, LOAD, CALC, WRITE, DONE;
  - BRAM_RD_LATENCY = 2;
  - DONE_HOLD = 5;
  - WE_ALL = 4'hF.
- One sub-module, pe_mac, holds the local RAM (write port, read port) and the accumulator (clear, enable, 32-bit MAC).
- pe_controller holds the FSM, counters and BRAM address generation.

Test Plan:
- A = all 1, B = 1..64, one-cycle start pulse → word 0 = 2080 (0x820); done high for 5 cycles, rising 134 cycles after start.
- A = B = 0..63 → word 0 = 85344 (0x14D60); only one BRAM write (WE = F) in the whole run, to address 0.
- A = all -1 (0xFFFFFFFF), B = all 2 → word 0 = 0xFFFFFF80 (-128).
- A = B = 0x00010000 → each product wraps to 0 → word 0 = 0; wrap-around check.
- start held high throughout a run → exactly one computation; a start pulse during CALC has no effect; a second start after done returns low recomputes the same value.
- aresetn = 1 asserted mid-CALC → next cycle done = 0, WE = 0, state IDLE; BRAM word 0 unchanged; a subsequent start gives the correct result.
